// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: loads the PU array, steps it until ESG signals end or the cap is hit, then reports the winner
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : run request (IDLE only)
//   end_signal, pu_zero      : convergence flag from ESG and per-PU zero flags
//   load, iter_en, done      : one-cycle pulses, decoded from state
//   busy                     : high from LOAD through DONE
//   winner, no_winner,       : registered result of the last run
//   timeout, iter_count
module maxnet_ctrl #(
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             end_signal,
  input  logic [3:0]       pu_zero,
  output logic             load,
  output logic             iter_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             no_winner,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE_L, S_STEP, S_SETTLE, S_RESOLVE, S_DONE
  } state_t;
  state_t r_state, w_next;
  logic       w_cap;
  logic [1:0] w_win;
  assign w_cap = iter_count == CNT_W'(MAX_ITER);
  // lowest-index surviving PU; all-zero falls through to 0 and is flagged by no_winner
  assign w_win = !pu_zero[0] ? 2'd0 : !pu_zero[1] ? 2'd1 : !pu_zero[2] ? 2'd2 : !pu_zero[3] ? 2'd3 : 2'd0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:     w_next = S_SETTLE_L;
      S_SETTLE_L: w_next = end_signal ? S_RESOLVE : S_STEP;
      S_STEP:     w_next = S_SETTLE;
      S_SETTLE:   w_next = (end_signal || w_cap) ? S_RESOLVE : S_STEP;
      S_RESOLVE:  w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      winner     <= '0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
      iter_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        winner     <= '0;
        no_winner  <= 1'b0;
        timeout    <= 1'b0;
        iter_count <= '0;
      end
      if (r_state == S_STEP) iter_count <= iter_count + CNT_W'(1);
      // end_signal has priority: a run that converges on the last allowed step is not a timeout
      if (r_state == S_SETTLE && !end_signal && w_cap) timeout <= 1'b1;
      if (r_state == S_RESOLVE) begin
        winner    <= w_win;
        no_winner <= &pu_zero;
      end
    end
  end
  assign load    = r_state == S_LOAD;
  assign iter_en = r_state == S_STEP;
  assign done    = r_state == S_DONE;
  assign busy    = r_state != S_IDLE;
endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb_maxnet_ctrl: scoreboard bench for maxnet_ctrl with an iteration-counting ESG model
module tb_maxnet_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, end_signal;
  logic [3:0] pu_zero;
  logic       load, iter_en, busy, done, no_winner, timeout;
  logic [1:0] winner;
  logic [7:0] iter_count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [1:0] w;
    logic       nw;
    logic       to;
    int         n;
  } exp_t;
  exp_t q[$];

  maxnet_ctrl #(.MAX_ITER(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .end_signal(end_signal), .pu_zero(pu_zero),
    .load(load), .iter_en(iter_en), .busy(busy), .done(done), .winner(winner),
    .no_winner(no_winner), .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // end_after: iterations after which the ESG model raises end_signal (-1 = never)
  task automatic run_case(input int end_after, input logic [3:0] pz, input logic [1:0] ew,
                          input logic enw, input logic eto, input int en,
                          input bit pre, input bit hold, input bit noise);
    int cyc, iters, last, loads;
    bit got;
    exp_t e;
    pu_zero = pz;
    end_signal = (end_after == 0);
    q.push_back('{ew, enw, eto, en});
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    cyc = 0; iters = 0; last = 0; loads = 0; got = 0;
    while (!got && cyc < 60) begin
      if (!(pre && cyc == 0)) @(negedge clk);
      cyc++;
      if (!hold) start = noise && (cyc == 4 || cyc == 5);
      if (load) loads++;
      if (iter_en) begin
        iters++;
        checks++;
        if (iters == 1 && cyc != 3) begin
          errors++; $display("FAIL first_iter cycle %0d required 3", cyc);
        end else if (iters > 1 && cyc - last != 2) begin
          errors++; $display("FAIL iter_spacing gap %0d required 2", cyc - last);
        end
        last = cyc;
      end
      end_signal = (end_after >= 0 && iters >= end_after);
      checks++;
      if (int'(load) + int'(iter_en) + int'(done) > 1) begin
        errors++; $display("FAIL pulse_excl load %b iter_en %b done %b required at most one", load, iter_en, done);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy cycle %0d got %b required 1", cyc, busy);
      end
      if (done === 1'b1) begin
        got = 1;
        e = q.pop_front();
        checks++;
        if (winner !== e.w) begin errors++; $display("FAIL winner got %0d required %0d", winner, e.w); end
        checks++;
        if (no_winner !== e.nw) begin errors++; $display("FAIL no_winner got %b required %b", no_winner, e.nw); end
        checks++;
        if (timeout !== e.to) begin errors++; $display("FAIL timeout got %b required %b", timeout, e.to); end
        checks++;
        if (iter_count !== 8'(e.n)) begin errors++; $display("FAIL iter_count got %0d required %0d", iter_count, e.n); end
        checks++;
        if (iters != e.n) begin errors++; $display("FAIL iter_pulses got %0d required %0d", iters, e.n); end
        checks++;
        if (loads != 1) begin errors++; $display("FAIL load_pulses got %0d required 1", loads); end
        checks++;
        if (cyc != 2 * e.n + 4) begin errors++; $display("FAIL done_cycle got %0d required %0d", cyc, 2 * e.n + 4); end
      end
    end
    if (!got) begin
      errors++; $display("FAIL no_done within 60 cycles");
      void'(q.pop_front());
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({load, iter_en, busy, done, winner, no_winner, timeout, iter_count} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b required 0", {load, iter_en, busy, done, winner, no_winner, timeout, iter_count});
    end
  endtask

  task automatic test_reset_mid_run;
    bit hit = 0;
    end_signal = 1'b0;
    pu_zero = 4'b0000;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (iter_en && iter_count == 8'd5) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reach_step5 got 0 required 1"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    test_reset;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (iter_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle iter_en %b busy %b required 0 0", iter_en, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_case(2, 4'b1101, 2'd1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || load !== 1'b0) begin
      errors++; $display("FAIL gap_idle busy %b load %b required 0 0", busy, load);
    end
    checks++;
    if (winner !== 2'd1 || iter_count !== 8'd2) begin
      errors++; $display("FAIL hold_results winner %0d iter_count %0d required 1 2", winner, iter_count);
    end
    @(negedge clk);
    checks++;
    if (load !== 1'b1) begin errors++; $display("FAIL b2b_load got %b required 1", load); end
    start = 1'b0;
    run_case(1, 4'b0111, 2'd3, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_start;
    run_case(2, 4'b0111, 2'd3, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (load !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL spurious_run load %b busy %b required 0 0", load, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; end_signal = 1'b0; pu_zero = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset;
    run_case(3, 4'b1011, 2'd2, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    run_case(0, 4'b1110, 2'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_case(-1, 4'b0101, 2'd1, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
    run_case(2, 4'b1111, 2'd0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    test_back_to_back;
    test_ignored_start;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
